latch_ctrl: RTL and testbench
=============================

# latch_ctrl

Clocked write controller sitting directly upstream of the level-sensitive `latch` block. It accepts single-word write requests, drives `latch` `d`, `enable` and `rst_n` with a guaranteed setup / open / hold window, and sequences the latch's power-on clear. It reports completion with a done pulse. Optionally it reads the latch output back and flags mismatches.

## Interface
Parameters:
- `SETUP_CYC`, 2: cycles `latch_d` is stable before `latch_enable` rises (0 allowed).
- `OPEN_CYC`, 4: cycles `latch_enable` is high (minimum 1).
- `HOLD_CYC`, 2: cycles `latch_d` is held after `latch_enable` falls (0 allowed).
- `INIT_CYC`, 4: cycles `latch_rst_n` is held low after reset release (minimum 1).
- `CNT_W`, 8: phase-counter width; every `*_CYC` value must be below 2^CNT_W.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: write request, sampled only in IDLE.
- `wr_data` in 1: bit to write, captured with `req`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse when a write completes.
- `latch_rst_n` out 1: drives `latch.rst_n`.
- `latch_enable` out 1: drives `latch.enable`.
- `latch_d` out 1: drives `latch.d`.
- `latch_q` in 1: from `latch.q`; used only with verify.
- `err` out 1: sticky readback mismatch; constant 0 without verify.

## Operation
- All outputs are registered and glitch-free.
- Reset values: `latch_rst_n`=0, `latch_enable`=0, `latch_d`=0, `busy`=1, `done`=0, `err`=0. State resets to INIT.
- INIT: hold `latch_rst_n`=0 for INIT_CYC cycles, then set it to 1 and go to IDLE. `latch_rst_n` stays 1 until the next `rst`.
- IDLE: `busy`=0. When `req`=1, capture `wr_data` into `latch_d` and go to SETUP. If SETUP_CYC=0, go straight to OPEN.
- SETUP: hold for SETUP_CYC cycles with `latch_enable`=0.
- OPEN: hold for OPEN_CYC cycles with `latch_enable`=1.
- HOLD: hold for HOLD_CYC cycles with `latch_enable`=0. After HOLD, go to CHECK (verify build) or IDLE.
- `latch_d` changes only on request acceptance. It is held through all phases and afterwards.
- A `req` while `busy`=1 is ignored. Requests are not queued.
- `done` is asserted during the first IDLE cycle after completion. A new `req` in that same cycle is accepted.
- Counter: one down-counter is loaded with (phase length − 1) on phase entry. The phase exits when the counter reads 0.
- Reset mid-operation: `rst` asynchronously forces INIT. `latch_enable` drops immediately and the full init sequence repeats.

## Timing
- With default parameters, `req` is sampled high at edge 0:
  - SETUP occupies cycles 1–2.
  - `latch_enable` is high in cycles 3–6.
  - HOLD occupies cycles 7–8.
  - `done` pulses in cycle 9 (no verify) or cycle 11 (verify).
- Write latency = 1 + SETUP_CYC + OPEN_CYC + HOLD_CYC cycles (+2 with verify).
- Back-to-back throughput is one write per latency period.

## Configuration
- Macro `LATCH_CTRL_VERIFY_EN`.
- Defined:
  - `latch_q` passes through a 2-flop synchronizer.
  - A CHECK state of 2 cycles follows HOLD.
  - On the last CHECK cycle, if the synchronized `latch_q` ≠ `latch_d`, `err` is set.
  - `err` is sticky; it clears on the next accepted `req` or on `rst`.
- Undefined:
  - No CHECK state.
  - `latch_q` is unused.
  - `err` is tied to 0.

## Structure
- Package `latch_ctrl_pkg`: state enum (INIT, IDLE, SETUP, OPEN, HOLD, CHECK), default cycle-count constants, and CHECK length constant (2).
- Sub-module `latch_ctrl_sync2`: 2-flop synchronizer with asynchronous active-high reset to 0. Instantiated only under `LATCH_CTRL_VERIFY_EN`.

## Test plan
- Reset release, defaults: `latch_rst_n`=0 for 4 cycles, then 1; `busy` falls on cycle 5; `latch_enable` stays 0 throughout.
- `req`=1, `wr_data`=1 in IDLE: `latch_d`=1 from cycle 1; `latch_enable` high exactly cycles 3–6; `done` pulses once in cycle 9; `latch_d` stays 1 afterwards.
- `req` pulsed in cycles 2 and 5 of an active write: ignored; exactly one enable window and one `done` pulse.
- `req` in the `done` cycle with `wr_data`=0: accepted; the second window starts with no gap; `latch_d` becomes 0.
- `rst` asserted during OPEN: `latch_enable` and `latch_rst_n` drop to 0 asynchronously; the full INIT sequence repeats; the aborted write produces no `done`.
- Verify build, bench forces `latch_q`=0 while writing 1: `err`=1 in cycle 11 alongside `done`; `err` clears on the next accepted `req`; a matching write leaves `err`=0.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// Shared types and default timing constants for the latch write controller.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        SETUP = 3'd2,
        OPEN  = 3'd3,
        HOLD  = 3'd4,
        CHECK = 3'd5
    } state_t;

    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_OPEN_CYC  = 4;
    localparam int DEF_HOLD_CYC  = 2;
    localparam int DEF_INIT_CYC  = 4;
    localparam int DEF_CNT_W     = 8;
    localparam int CHECK_CYC     = 2;

endpackage

// File: rtl/latch_ctrl_sync2.sv
// Two-flop synchronizer for the latch readback; resets to 0.
module latch_ctrl_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/latch_ctrl.sv
// Write sequencer for the level-sensitive latch: init clear, setup/open/hold window, done pulse.
// Optional readback verification is enabled with the LATCH_CTRL_VERIFY_EN macro.
module latch_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int OPEN_CYC  = DEF_OPEN_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int INIT_CYC  = DEF_INIT_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic wr_data,
    output logic busy,
    output logic done,
    output logic latch_rst_n,
    output logic latch_enable,
    output logic latch_d,
    input  logic latch_q,
    output logic err
);

    localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CHECK_LD = CNT_W'(CHECK_CYC - 1);

`ifdef LATCH_CTRL_VERIFY_EN
    localparam state_t AFTER_HOLD = CHECK;
`else
    localparam state_t AFTER_HOLD = IDLE;
`endif
    // Zero-length phases are skipped entirely rather than visited for one cycle.
    localparam state_t AFTER_IDLE = (SETUP_CYC > 0) ? SETUP : OPEN;
    localparam state_t AFTER_OPEN = (HOLD_CYC > 0) ? HOLD : AFTER_HOLD;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             finish;
    logic             chk_last;

    function automatic logic [CNT_W-1:0] load_for(input state_t s);
        case (s)
            INIT:    return INIT_LD;
            SETUP:   return SETUP_LD;
            OPEN:    return OPEN_LD;
            HOLD:    return HOLD_LD;
            CHECK:   return CHECK_LD;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        chk_last   = 1'b0;
        case (state)
            INIT:  if (cnt == '0) state_next = IDLE;
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = AFTER_IDLE;
                end
            end
            SETUP: if (cnt == '0) state_next = OPEN;
            OPEN:  if (cnt == '0) state_next = AFTER_OPEN;
            HOLD:  if (cnt == '0) state_next = AFTER_HOLD;
            CHECK: begin
                if (cnt == '0) begin
                    chk_last   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = INIT;
        endcase

        if (state_next != state)
            cnt_next = load_for(state_next);
        else if (cnt != '0)
            cnt_next = cnt - CNT_W'(1);
        else
            cnt_next = cnt;

        // The init-to-idle transition is not a completed write.
        finish = (state_next == IDLE) && (state != IDLE) && (state != INIT);
    end

    // Outputs are registered from the next state so they change cleanly on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= INIT;
            cnt          <= INIT_LD;
            latch_rst_n  <= 1'b0;
            latch_enable <= 1'b0;
            latch_d      <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            latch_rst_n  <= (state_next != INIT);
            latch_enable <= (state_next == OPEN);
            busy         <= (state_next != IDLE);
            done         <= finish;
            if (accept)
                latch_d <= wr_data;
        end
    end

`ifdef LATCH_CTRL_VERIFY_EN
    logic q_sync;

    latch_ctrl_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (latch_q),
        .q   (q_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (accept)
            err <= 1'b0;
        else if (chk_last && (q_sync != latch_d))
            err <= 1'b1;
    end
`else
    logic [1:0] unused_sig;
    assign unused_sig = {latch_q, chk_last};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_latch_ctrl.sv
// Directed bench for latch_ctrl; verify-build checks follow LATCH_CTRL_VERIFY_EN.
module tb_latch_ctrl;

`ifdef LATCH_CTRL_VERIFY_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 9;
`endif

    logic clk = 1'b0;
    logic rst, req, wr_data;
    logic busy, done, latch_rst_n, latch_enable, latch_d, latch_q, err;
    logic lq, force_bad;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    latch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .latch_rst_n  (latch_rst_n),
        .latch_enable (latch_enable),
        .latch_d      (latch_d),
        .latch_q      (latch_q),
        .err          (err)
    );

    // Behavioural stand-in for the downstream latch, with a stuck-at-0 fault option.
    always_latch begin
        if (!latch_rst_n)
            lq <= 1'b0;
        else if (latch_enable)
            lq <= latch_d;
    end
    assign latch_q = force_bad ? 1'b0 : lq;

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Samples cycles 1..n mid-cycle; req is re-driven high at cycles ra/rb with data wd.
    task automatic run_cycles(input int n, input int ra, input int rb, input logic wd,
                              output logic [31:0] en_m, output logic [31:0] done_m,
                              output logic [31:0] busy_m, output logic [31:0] d_m,
                              output logic [31:0] err_m);
        en_m = '0; done_m = '0; busy_m = '0; d_m = '0; err_m = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            en_m[k]   = latch_enable;
            done_m[k] = done;
            busy_m[k] = busy;
            d_m[k]    = latch_d;
            err_m[k]  = err;
            req       = (k == ra) || (k == rb);
            if (req) wr_data = wd;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rn_m = '0, bz_m = '0, en_m = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({latch_rst_n, latch_enable, latch_d, busy, done, err} !== 6'b000100) begin
            fails++;
            $display("FAIL reset_values got %b want 000100", {latch_rst_n, latch_enable, latch_d, busy, done, err});
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            rn_m[k] = latch_rst_n;
            bz_m[k] = busy;
            en_m[k] = latch_enable;
        end
        tests++;
        if (rn_m !== win(5, 8)) begin fails++; $display("FAIL init_rst_n got %h want %h", rn_m, win(5, 8)); end
        tests++;
        if (bz_m !== win(1, 4)) begin fails++; $display("FAIL init_busy got %h want %h", bz_m, win(1, 4)); end
        tests++;
        if (en_m !== 32'h0) begin fails++; $display("FAIL init_enable got %h want 0", en_m); end
    endtask

    task automatic test_single_write();
        logic [31:0] en_m, done_m, busy_m, d_m, err_m;
        @(negedge clk);
        req = 1'b1; wr_data = 1'b1;
        run_cycles(LAT + 3, -1, -1, 1'b0, en_m, done_m, busy_m, d_m, err_m);
        tests++;
        if (en_m !== win(3, 6)) begin fails++; $display("FAIL single_enable got %h want %h", en_m, win(3, 6)); end
        tests++;
        if (done_m !== win(LAT, LAT)) begin fails++; $display("FAIL single_done got %h want %h", done_m, win(LAT, LAT)); end
        tests++;
        if (d_m !== win(1, LAT + 3)) begin fails++; $display("FAIL single_d got %h want %h", d_m, win(1, LAT + 3)); end
        tests++;
        if (busy_m !== win(1, LAT - 1)) begin fails++; $display("FAIL single_busy got %h want %h", busy_m, win(1, LAT - 1)); end
        tests++;
        if (err_m !== 32'h0) begin fails++; $display("FAIL single_err got %h want 0", err_m); end
    endtask

    task automatic test_ignored_req();
        logic [31:0] en_m, done_m, busy_m, d_m, err_m;
        @(negedge clk);
        req = 1'b1; wr_data = 1'b0;
        run_cycles(LAT + 3, 2, 5, 1'b1, en_m, done_m, busy_m, d_m, err_m);
        tests++;
        if (en_m !== win(3, 6)) begin fails++; $display("FAIL ignored_enable got %h want %h", en_m, win(3, 6)); end
        tests++;
        if (done_m !== win(LAT, LAT)) begin fails++; $display("FAIL ignored_done got %h want %h", done_m, win(LAT, LAT)); end
        tests++;
        if (d_m !== 32'h0) begin fails++; $display("FAIL ignored_d got %h want 0", d_m); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] en_m, done_m, busy_m, d_m, err_m;
        @(negedge clk);
        req = 1'b1; wr_data = 1'b1;
        run_cycles(2 * LAT + 3, LAT, -1, 1'b0, en_m, done_m, busy_m, d_m, err_m);
        tests++;
        if (en_m !== (win(3, 6) | win(LAT + 3, LAT + 6))) begin
            fails++; $display("FAIL b2b_enable got %h want %h", en_m, win(3, 6) | win(LAT + 3, LAT + 6));
        end
        tests++;
        if (done_m !== (win(LAT, LAT) | win(2 * LAT, 2 * LAT))) begin
            fails++; $display("FAIL b2b_done got %h want %h", done_m, win(LAT, LAT) | win(2 * LAT, 2 * LAT));
        end
        tests++;
        if (d_m !== win(1, LAT)) begin fails++; $display("FAIL b2b_d got %h want %h", d_m, win(1, LAT)); end
        tests++;
        if (busy_m !== (win(1, LAT - 1) | win(LAT + 1, 2 * LAT - 1))) begin
            fails++; $display("FAIL b2b_busy got %h want %h", busy_m, win(1, LAT - 1) | win(LAT + 1, 2 * LAT - 1));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] en_m, done_m, busy_m, d_m, err_m;
        logic [31:0] rn_m = '0, dn_m = '0, bz_m = '0, e2_m = '0;
        @(negedge clk);
        req = 1'b1; wr_data = 1'b1;
        run_cycles(4, -1, -1, 1'b0, en_m, done_m, busy_m, d_m, err_m);
        tests++;
        if (latch_enable !== 1'b1) begin fails++; $display("FAIL mid_open_enable got %b want 1", latch_enable); end
        rst = 1'b1;
        #1;
        tests++;
        if ({latch_enable, latch_rst_n, busy, latch_d} !== 4'b0010) begin
            fails++; $display("FAIL mid_async got %b want 0010", {latch_enable, latch_rst_n, busy, latch_d});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            rn_m[k] = latch_rst_n;
            dn_m[k] = done;
            bz_m[k] = busy;
            e2_m[k] = latch_enable;
        end
        tests++;
        if (rn_m !== win(5, 14)) begin fails++; $display("FAIL mid_rst_n got %h want %h", rn_m, win(5, 14)); end
        tests++;
        if (bz_m !== win(1, 4)) begin fails++; $display("FAIL mid_busy got %h want %h", bz_m, win(1, 4)); end
        tests++;
        if ((dn_m | e2_m) !== 32'h0) begin fails++; $display("FAIL mid_no_done got %h want 0", dn_m | e2_m); end
    endtask

    task automatic test_verify();
        logic [31:0] en_m, done_m, busy_m, d_m, err_m;
        force_bad = 1'b1;
        @(negedge clk);
        req = 1'b1; wr_data = 1'b1;
        run_cycles(LAT + 3, -1, -1, 1'b0, en_m, done_m, busy_m, d_m, err_m);
`ifdef LATCH_CTRL_VERIFY_EN
        tests++;
        if (err_m !== win(11, 14)) begin fails++; $display("FAIL verify_err_set got %h want %h", err_m, win(11, 14)); end
        tests++;
        if (done_m !== win(11, 11)) begin fails++; $display("FAIL verify_done got %h want %h", done_m, win(11, 11)); end
        force_bad = 1'b0;
        @(negedge clk);
        req = 1'b1; wr_data = 1'b1;
        run_cycles(LAT + 3, -1, -1, 1'b0, en_m, done_m, busy_m, d_m, err_m);
        tests++;
        if (err_m !== 32'h0) begin fails++; $display("FAIL verify_err_clear got %h want 0", err_m); end
        tests++;
        if (done_m !== win(11, 11)) begin fails++; $display("FAIL verify_done2 got %h want %h", done_m, win(11, 11)); end
`else
        tests++;
        if (err_m !== 32'h0) begin fails++; $display("FAIL err_tied got %h want 0", err_m); end
        tests++;
        if (done_m !== win(9, 9)) begin fails++; $display("FAIL err_tied_done got %h want %h", done_m, win(9, 9)); end
        force_bad = 1'b0;
`endif
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr_data = 1'b0; force_bad = 1'b0;
        test_reset();
        test_single_write();
        test_ignored_req();
        test_back_to_back();
        test_reset_mid();
        test_verify();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
